// File: rtl/hi_flite_ts_sched.sv
// hi_flite tag-response timeslot scheduler: counts the slot delay after a reader frame, then Manchester-modulates ARM bits.
// Optional build macro FELICA_PREAMBLE_EN: block emits the 48-bit zero preamble and 0xB24D sync itself.
module hi_flite_ts_sched #(
    parameter int TS0_BITS   = 512,
    parameter int TSLOT_BITS = 256
) (
    input  logic       i_ck_1356meg,
    input  logic       i_rst,
    input  logic       i_speed,
    input  logic [3:0] i_ts_num,
    input  logic       i_frame_end,
    input  logic       i_resp_pend,
    input  logic       i_bit_valid,
    input  logic       i_tx_data,
    output logic       o_bit_ready,
    output logic       o_mod_out,
    output logic       o_busy,
    output logic       o_missed
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_TX   = 2'd2
`ifdef FELICA_PREAMBLE_EN
        , ST_PRE = 2'd3
`endif
    } state_t;

    localparam logic [12:0] TS0   = 13'(TS0_BITS);
    localparam logic [12:0] TSLOT = 13'(TSLOT_BITS);

`ifdef FELICA_PREAMBLE_EN
    localparam int          PREAMBLE_BITS = 48;
    localparam logic [12:0] PRE_TOTAL     = 13'(PREAMBLE_BITS + 16);
    localparam logic [15:0] SYNC_WORD     = 16'hB24D;

    // Preamble/sync bit for a given bit index within the generated header.
    function automatic logic pre_bit(input logic [12:0] idx);
        logic [12:0] off;
        off = idx - 13'(PREAMBLE_BITS);
        if (idx < 13'(PREAMBLE_BITS)) begin
            return 1'b0;
        end else begin
            return SYNC_WORD[4'd15 - off[3:0]];
        end
    endfunction
`endif

    state_t      r_state;
    logic [5:0]  r_tick;
    logic [12:0] r_bit_cnt;
    logic        r_speed;
    logic [3:0]  r_ts_num;
    logic        r_cur_bit;
    logic        r_bit_ready;
    logic        r_mod_out;
    logic        r_busy;
    logic        r_missed;

    state_t      w_state;
    logic [5:0]  w_tick;
    logic [12:0] w_bit_cnt;
    logic        w_speed;
    logic [3:0]  w_ts_num;
    logic        w_cur_bit;
    logic        w_bit_ready;
    logic        w_mod_out;
    logic        w_busy;
    logic        w_missed;

    logic        w_wrap;
    logic [5:0]  w_tick_inc;
    logic [12:0] w_bit_cnt_inc;
    logic [12:0] w_target;

    assign w_wrap        = (r_tick == (r_speed ? 6'd31 : 6'd63));
    assign w_tick_inc    = w_wrap ? 6'd0 : (r_tick + 6'd1);
    assign w_bit_cnt_inc = r_bit_cnt + 13'd1;
    assign w_target      = TS0 + (TSLOT * {9'd0, r_ts_num});

    // Next-state and datapath update; the slot-start wrap doubles as the first bit boundary.
    always_comb begin
        w_state     = r_state;
        w_tick      = r_tick;
        w_bit_cnt   = r_bit_cnt;
        w_speed     = r_speed;
        w_ts_num    = r_ts_num;
        w_cur_bit   = r_cur_bit;
        w_bit_ready = 1'b0;
        w_missed    = r_missed;
        case (r_state)
            ST_IDLE: begin
                if (i_frame_end) begin
                    w_state   = ST_WAIT;
                    w_speed   = i_speed;
                    w_ts_num  = i_ts_num;
                    w_tick    = 6'd0;
                    w_bit_cnt = 13'd0;
                    w_missed  = 1'b0;
                end else begin
                    w_tick    = 6'd0;
                    w_bit_cnt = 13'd0;
                    w_cur_bit = 1'b0;
                end
            end
            ST_WAIT: begin
                if (i_frame_end) begin
                    w_ts_num  = i_ts_num;
                    w_tick    = 6'd0;
                    w_bit_cnt = 13'd0;
                end else begin
                    w_tick = w_tick_inc;
                    if (w_wrap) begin
                        w_bit_cnt = w_bit_cnt_inc;
                        if (w_bit_cnt_inc == w_target) begin
                            if (i_resp_pend && i_bit_valid) begin
`ifdef FELICA_PREAMBLE_EN
                                w_state   = ST_PRE;
                                w_bit_cnt = 13'd0;
                                w_cur_bit = pre_bit(13'd0);
`else
                                w_state     = ST_TX;
                                w_cur_bit   = i_tx_data;
                                w_bit_ready = 1'b1;
`endif
                            end else begin
                                w_state  = ST_IDLE;
                                w_missed = 1'b1;
                            end
                        end else begin
                            w_state = ST_WAIT;
                        end
                    end else begin
                        w_bit_cnt = r_bit_cnt;
                    end
                end
            end
`ifdef FELICA_PREAMBLE_EN
            ST_PRE: begin
                w_tick = w_tick_inc;
                if (w_wrap) begin
                    if (w_bit_cnt_inc == PRE_TOTAL) begin
                        if (i_bit_valid) begin
                            w_state     = ST_TX;
                            w_cur_bit   = i_tx_data;
                            w_bit_ready = 1'b1;
                        end else begin
                            w_state   = ST_IDLE;
                            w_cur_bit = 1'b0;
                        end
                    end else begin
                        w_bit_cnt = w_bit_cnt_inc;
                        w_cur_bit = pre_bit(w_bit_cnt_inc);
                    end
                end else begin
                    w_cur_bit = r_cur_bit;
                end
            end
`endif
            ST_TX: begin
                w_tick = w_tick_inc;
                if (w_wrap) begin
                    if (i_bit_valid) begin
                        w_cur_bit   = i_tx_data;
                        w_bit_ready = 1'b1;
                    end else begin
                        w_state   = ST_IDLE;
                        w_cur_bit = 1'b0;
                    end
                end else begin
                    w_cur_bit = r_cur_bit;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // Output decode from next-state values so mod_out lines up with the tick phase it encodes.
    always_comb begin
        w_busy    = (w_state != ST_IDLE);
        w_mod_out = 1'b0;
`ifdef FELICA_PREAMBLE_EN
        if ((w_state == ST_TX) || (w_state == ST_PRE)) begin
`else
        if (w_state == ST_TX) begin
`endif
            w_mod_out = w_cur_bit ^ (w_tick >= (w_speed ? 6'd16 : 6'd32));
        end else begin
            w_mod_out = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_ck_1356meg) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_tick      <= 6'd0;
            r_bit_cnt   <= 13'd0;
            r_speed     <= 1'b0;
            r_ts_num    <= 4'd0;
            r_cur_bit   <= 1'b0;
            r_bit_ready <= 1'b0;
            r_mod_out   <= 1'b0;
            r_busy      <= 1'b0;
            r_missed    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_tick      <= w_tick;
            r_bit_cnt   <= w_bit_cnt;
            r_speed     <= w_speed;
            r_ts_num    <= w_ts_num;
            r_cur_bit   <= w_cur_bit;
            r_bit_ready <= w_bit_ready;
            r_mod_out   <= w_mod_out;
            r_busy      <= w_busy;
            r_missed    <= w_missed;
        end
    end

    assign o_bit_ready = r_bit_ready;
    assign o_mod_out   = r_mod_out;
    assign o_busy      = r_busy;
    assign o_missed    = r_missed;

endmodule

// File: tb/tb_hi_flite_ts_sched.sv
// Bench for hi_flite_ts_sched: timeline model (slot start edge + bit period arithmetic) compared every cycle,
// plus literal timing expectations for the slot delays, pulse spacing, missed slot and reset.
`timescale 1ns/1ps
module tb_hi_flite_ts_sched;
`ifdef FELICA_PREAMBLE_EN
    localparam int OFF = 64;
`else
    localparam int OFF = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       speed = 1'b0;
    logic [3:0] ts_num = 4'd0;
    logic       frame_end = 1'b0;
    logic       resp_pend = 1'b0;
    logic       bit_valid, tx_data;
    logic       bit_ready, mod_out, busy, missed;

    logic       resp_bits [0:63];
    int         resp_len = 0;
    int         base = 0;
    int         ready_cnt = 0;
    logic [5:0] arm_idx;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [15:0] sync_word = 16'hB24D;

    hi_flite_ts_sched dut (
        .i_ck_1356meg (clk),
        .i_rst        (rst),
        .i_speed      (speed),
        .i_ts_num     (ts_num),
        .i_frame_end  (frame_end),
        .i_resp_pend  (resp_pend),
        .i_bit_valid  (bit_valid),
        .i_tx_data    (tx_data),
        .o_bit_ready  (bit_ready),
        .o_mod_out    (mod_out),
        .o_busy       (busy),
        .o_missed     (missed)
    );

    always #5 clk = ~clk;

    // ARM side: present bit (ready_cnt - base) of the queued response, advance on each bit_ready
    assign arm_idx   = 6'(ready_cnt - base);
    assign bit_valid = ((ready_cnt - base) < resp_len);
    assign tx_data   = resp_bits[arm_idx];

    always @(negedge clk) begin
        if (bit_ready === 1'b1) ready_cnt <= ready_cnt + 1;
    end

    // Reference model: 0 idle, 1 waiting, 2 transmitting; m_s is the edge index of slot start
    int   m_mode = 0;
    int   m_s = 0;
    int   m_bp = 64;
    int   m_n = 0;
    logic m_missed = 1'b0;
    logic m_init = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_mode   <= 0;
            m_missed <= 1'b0;
            m_init   <= 1'b1;
        end else begin
            case (m_mode)
                0: if (frame_end) begin
                    m_mode   <= 1;
                    m_bp     <= speed ? 32 : 64;
                    m_s      <= cyc + (512 + 256 * int'(ts_num)) * (speed ? 32 : 64);
                    m_missed <= 1'b0;
                end
                1: if (frame_end) begin
                    m_s <= cyc + (512 + 256 * int'(ts_num)) * m_bp;
                end else if (cyc == m_s) begin
                    if (resp_pend && bit_valid) begin
                        m_mode <= 2;
                        m_n    <= resp_len;
                    end else begin
                        m_mode   <= 0;
                        m_missed <= 1'b1;
                    end
                end
                2: if (cyc == m_s + (OFF + m_n) * m_bp) m_mode <= 0;
                default: m_mode <= 0;
            endcase
        end
    end

    logic e_ready, e_mod, e_busy, e_missed, e_bit;
    int   e_rel, e_k, e_ph, e_j, e_sidx;

    always_comb begin
        e_ready  = 1'b0;
        e_mod    = 1'b0;
        e_busy   = (m_mode != 0);
        e_missed = m_missed;
        e_bit    = 1'b0;
        e_rel    = 0;
        e_k      = 0;
        e_ph     = 0;
        e_j      = 0;
        e_sidx   = 0;
        if (m_mode == 2) begin
            e_rel = cyc - 1 - m_s;
            e_k   = e_rel / m_bp;
            e_ph  = e_rel % m_bp;
            e_j   = e_k - OFF;
            if (e_j >= 0) begin
                e_bit = resp_bits[e_j[5:0]];
            end else if (e_k >= 48) begin
                e_sidx = 15 - (e_k - 48);
                e_bit  = sync_word[e_sidx[3:0]];
            end else begin
                e_bit = 1'b0;
            end
            e_ready = (e_ph == 0) && (e_j >= 0);
            e_mod   = e_bit ^ (e_ph >= m_bp / 2);
        end
    end

    task automatic step();
        @(negedge clk);
        if (m_init) begin
            n_checks++;
            if ({bit_ready, mod_out, busy, missed} !== {e_ready, e_mod, e_busy, e_missed}) begin
                n_fail++;
                if (n_fail <= 20)
                    $display("FAIL cycle_cmp edge %0d: rdy/mod/busy/missed got %b expected %b",
                             cyc - 1, {bit_ready, mod_out, busy, missed}, {e_ready, e_mod, e_busy, e_missed});
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_resp(input int n);
        for (int i = 0; i < 64; i++) resp_bits[i] = 1'($urandom_range(0, 1));
        resp_len = n;
        base     = ready_cnt;
    endtask

    task automatic pulse_fe(output int fe);
        frame_end = 1'b1;
        fe        = cyc;
        step();
        frame_end = 1'b0;
    endtask

    task automatic wait_ready(input int lim, output logic found, output int t);
        found = 1'b0;
        t     = 0;
        for (int i = 0; i < lim && !found; i++) begin
            step();
            if (bit_ready) begin
                found = 1'b1;
                t     = cyc - 1;
            end
        end
    endtask

    int   fe, fe2, t, last, npulse, fe_at, cnt;
    logic found, seen_mod, seen_rdy;

    initial begin
        repeat (3) step();
        chk("reset_bit_ready", int'(bit_ready), 0);
        chk("reset_mod_out", int'(mod_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_missed", int'(missed), 0);
        rst = 1'b0;
        repeat (5) step();

        // slot 0 at 212 kbps, 8 bits, a stray frame_end during TX
        load_resp(8);
        speed = 1'b0; ts_num = 4'd0; resp_pend = 1'b1;
        pulse_fe(fe);
        chk("t1_busy_after_fe", int'(busy), 1);
        wait_ready(40000, found, t);
        chk("t1_first_ready_found", int'(found), 1);
        chk("t1_first_ready_delay", t - fe, 32768 + OFF * 64);
        npulse = 1; last = t;
        fe_at = int'($urandom_range(70, 300));
        for (int i = 0; i < 3000 && busy; i++) begin
            frame_end = (i == fe_at);
            step();
            if (bit_ready) begin
                chk("t1_pulse_gap", cyc - 1 - last, 64);
                last = cyc - 1;
                npulse++;
            end
        end
        frame_end = 1'b0;
        chk("t1_pulse_count", npulse, 8);
        chk("t1_busy_drop", cyc - 1 - fe, 32768 + (OFF + 8) * 64);
        chk("t1_mod_idle", int'(mod_out), 0);
        repeat (10) step();

        // slot 1 at 424 kbps with input noise in WAIT, reset during bit 3
        load_resp(12);
        speed = 1'b1; ts_num = 4'd1; resp_pend = 1'b1;
        pulse_fe(fe);
        for (int i = 0; i < 300; i++) begin
            step();
            speed  = 1'($urandom_range(0, 1));
            ts_num = 4'($urandom_range(0, 15));
        end
        wait_ready(30000, found, t);
        chk("t2_first_ready_found", int'(found), 1);
        chk("t2_first_ready_delay", t - fe, 24576 + OFF * 32);
        cnt = 1;
        for (int i = 0; i < 500 && cnt < 4; i++) begin
            step();
            if (bit_ready) cnt++;
        end
        chk("t2_pulses_before_rst", cnt, 4);
        repeat ($urandom_range(1, 30)) step();
        rst = 1'b1;
        step();
        chk("t2_rst_mod_out", int'(mod_out), 0);
        chk("t2_rst_bit_ready", int'(bit_ready), 0);
        chk("t2_rst_busy", int'(busy), 0);
        rst = 1'b0;
        seen_rdy = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bit_ready) seen_rdy = 1'b1;
        end
        chk("t2_no_ready_after_rst", int'(seen_rdy), 0);

        // superseding frame_end in WAIT, then an unanswered slot
        load_resp(4);
        resp_pend = 1'b0; speed = 1'b1; ts_num = 4'd5;
        pulse_fe(fe);
        for (int i = 0; i < 1000 + int'($urandom_range(0, 200)); i++) begin
            step();
            speed = 1'($urandom_range(0, 1));
        end
        ts_num = 4'd0;
        pulse_fe(fe2);
        found = 1'b0; seen_mod = 1'b0; seen_rdy = 1'b0; t = 0;
        for (int i = 0; i < 20000 && !found; i++) begin
            step();
            if (mod_out) seen_mod = 1'b1;
            if (bit_ready) seen_rdy = 1'b1;
            if (missed) begin
                found = 1'b1;
                t     = cyc - 1;
            end
        end
        chk("t3_missed_found", int'(found), 1);
        chk("t3_missed_delay", t - fe2, 16384);
        chk("t3_busy_low", int'(busy), 0);
        chk("t3_mod_never", int'(seen_mod), 0);
        chk("t3_ready_never", int'(seen_rdy), 0);
        repeat (20) step();
        chk("t3_missed_sticky", int'(missed), 1);
        pulse_fe(fe);
        chk("t3_missed_cleared", int'(missed), 0);
        chk("t3_busy_again", int'(busy), 1);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("t3_idle_after_rst", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
